aria_sl_seq: RTL
================

Name: aria_sl_seq

Overview:
- Iterative controller for the ARIA substitution layer.
- Accepts a 128-bit state and the substitution type (SL1 for odd rounds, SL2 for even rounds).
- Time-multiplexes a shared S-box lane bank (S1, S2, S1 inversion, S2 inversion per byte lane) over the state, NWORD 32-bit words per cycle.
- Returns the substituted 128-bit state to the round datapath over a valid/ready handshake.

Parameters:
- NWORD, 1, number of 32-bit words substituted per cycle. Legal values: 1, 2, 4. Any other value is a synthesis-time error.
- NSTEP, 4/NWORD, derived (localparam): run cycles per block.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sl_in_valid  input  1  input block valid.
- sl_in_ready  output  1  block accepted when sl_in_valid && sl_in_ready.
- sl_type  input  1  0 = SL1, 1 = SL2. Sampled at input handshake.
- sl_din  input  128  input state. byte0 = [127:120], word0 = [127:96].
- sl_out_valid  output  1  substituted block available.
- sl_out_ready  input  1  consumer accepts when sl_out_valid && sl_out_ready.
- sl_dout  output  128  substituted state, registered.
- sl_busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; step counter = 0; type register = 0.
  - Data register = 0; sl_dout = 0.
  - sl_in_ready = 1; sl_out_valid = 0; sl_busy = 0.
- Byte lane map, per 32-bit word:
  - SL1: byte positions 0..3 → S1, S2, S1i, S2i.
  - SL2: byte positions 0..3 → S1i, S2i, S1, S2.
  - Lane k selects between its two S-boxes on the registered type. It does not read sl_type after acceptance.
- FSM states:
  - IDLE: sl_in_ready = 1. On input handshake: latch sl_din into the data register, latch sl_type, counter = 0, go to RUN.
  - RUN: sl_in_ready = 0. Each cycle substitute words [counter*NWORD .. counter*NWORD+NWORD-1] in place in the data register, counter += 1. When counter == NSTEP-1, perform the final substitution and go to DONE; counter wraps to 0.
  - DONE: sl_out_valid = 1 and sl_dout = data register, held stable until handshake. On output handshake go to IDLE.
- Latency:
  - Input handshake in cycle T.
  - sl_out_valid rises at edge T+1+NSTEP (NWORD=1: 5 edges).
  - Minimum initiation interval NSTEP+2 cycles. There is no overlap: sl_in_ready is low in DONE, even if sl_out_ready is high in the same cycle.
- Word processing order is ascending (word0 first). Words not yet processed hold their input value.
- Backpressure: sl_out_ready low holds DONE indefinitely. sl_dout, sl_out_valid and the type register stay constant.
- sl_in_valid while not IDLE: ignored. No data is captured.
- sl_out_ready while not DONE: ignored.
- Reset mid-RUN or mid-DONE: the block is abandoned immediately and all values return to the reset values. There is no partial output.
- Counter width: 2 bits. Only 0..NSTEP-1 are legal. In any state other than RUN the counter is forced to 0.
- Unused FSM encodings: recover to IDLE on the next clock edge.

Optional Feature:
ARIA_SL_ZEROIZE_EN:
- Defined:
  - The data register is cleared to 0 on the output handshake edge, so sl_dout reads 0 whenever sl_out_valid is low after the first block.
  - The type register is cleared on the same edge.
- Undefined:
  - The data register retains the last result until the next input handshake overwrites it.
- In both cases the handshake timing is identical.

Test Plan:
1. Reset, then sl_din=0, sl_type=0, NWORD=1 → after 5 edges sl_out_valid=1 and sl_dout = 0x63E25230 repeated 4 times (0x63E2523063E2523063E2523063E25230).
2. sl_din=0, sl_type=1 → sl_dout = 0x523063E2 repeated 4 times. Repeat with NWORD=2 and NWORD=4: sl_out_valid at edge 3 and edge 2 after handshake respectively, same data.
3. Hold sl_out_ready=0 for 10 cycles in DONE, and pulse sl_in_valid with new data during that time → sl_dout unchanged, sl_in_ready=0 throughout. On release: one output handshake, then sl_in_ready=1 on the next cycle.
4. Drop rst_n during RUN at counter=2 → outputs go to reset values asynchronously, with no sl_out_valid pulse. A block accepted after reset is processed correctly per scenario 1.
5. Back-to-back blocks, SL1 then SL2, with sl_out_ready tied high → per-block interval of exactly NSTEP+2 cycles and correct per-type results. With ARIA_SL_ZEROIZE_EN, sl_dout = 0 in the cycle after each output handshake.

Source files
------------

// File: rtl/aria_sl_if.sv
// Valid/ready bundle between the ARIA round datapath (master) and the
// substitution-layer sequencer (slave).
interface aria_sl_if;
   logic         sl_in_valid;
   logic         sl_in_ready;
   logic         sl_type;
   logic [127:0] sl_din;
   logic         sl_out_valid;
   logic         sl_out_ready;
   logic [127:0] sl_dout;
   logic         sl_busy;

   modport master (
      output sl_in_valid, sl_type, sl_din, sl_out_ready,
      input  sl_in_ready, sl_out_valid, sl_dout, sl_busy
   );

   modport slave (
      input  sl_in_valid, sl_type, sl_din, sl_out_ready,
      output sl_in_ready, sl_out_valid, sl_dout, sl_busy
   );
endinterface

// File: rtl/aria_sl_seq.sv
// Iterative ARIA substitution layer: NWORD 32-bit words per cycle through a shared
// S1/S2/S1i/S2i lane bank. Optional macro ARIA_SL_ZEROIZE_EN clears state after delivery.
module aria_sl_seq #(
   parameter int NWORD = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   aria_sl_if.slave  sl
);
   localparam int         NSTEP     = 4 / NWORD;
   localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

   if (NWORD != 1 && NWORD != 2 && NWORD != 4) begin : g_bad_nword
      $error("aria_sl_seq: NWORD must be 1, 2 or 4");
   end

   // ARIA S2, entry 0 leftmost; S2 inverse is derived from it by search.
   localparam logic [0:255][7:0] S2_TAB = {
      128'he24e54fc_94c24acc_620d6a46_3c4d8bd1, 128'h5efa64cb_b497be2b_bc772e03_d31959c1,
      128'h1d06416b_55f09969_ea9c18ae_63dfe7bb, 128'h007366fb_964c85e4_3a0945aa_0fee10eb,
      128'h2d7ff429_accfad91_8d78c895_f92fcecd, 128'h087a8838_5c832a28_47dbb8c7_93a41253,
      128'hff870e31_36215848_018e3774_32cae9b1, 128'hb7ab0cd7_c4564226_079860d9_b6b91140,
      128'hec208cbd_a0c98404_4923f14f_501f13dc, 128'hd8c09e57_e3c37b65_3b028f3e_e82592e5,
      128'h15ddfd17_a9bfd49a_7ec53967_fe769d43, 128'ha7e1d0f5_68f21b34_7005a38a_d57986a8,
      128'h30c6514b_1ea627f6_35d26e24_16825fda, 128'he675a2ef_2cb21c9f_5d6f800a_72449b6c,
      128'h900b5b33_7d5a52f3_61a1f7b0_d63f7c6d, 128'hed14e0a5_3d22b3f8_89de711a_afbab581
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; 0 maps to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, p);
         p = gf_mul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sb1(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sb1_inv(input logic [7:0] x);
      return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] sb2_inv(input logic [7:0] x);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 256; i++) begin
         if (S2_TAB[i] == x) r = 8'(i);
      end
      return r;
   endfunction

   // Lane k uses box k for SL1; SL2 swaps forward/inverse, i.e. flips box bit 1.
   function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic [1:0] lane,
                                           input logic t);
      logic [1:0] box;
      logic [7:0] y;
      box = lane ^ {t, 1'b0};
      case (box)
         2'd0:    y = sb1(x);
         2'd1:    y = S2_TAB[x];
         2'd2:    y = sb1_inv(x);
         default: y = sb2_inv(x);
      endcase
      return y;
   endfunction

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         type_q, type_d;
   logic [127:0] data_q, data_d;
   logic [127:0] dout_q, dout_d;
   logic         in_ready, out_valid, busy;

   logic [NWORD-1:0][1:0]  widx;
   logic [NWORD-1:0][31:0] lane_in;
   logic [NWORD-1:0][31:0] lane_out;
   logic [127:0]           data_sub;

   always_comb begin
      data_sub = data_q;
      for (int w = 0; w < NWORD; w++) begin
         widx[w]    = 2'(int'(cnt_q) * NWORD + w);
         lane_in[w] = data_q[127 - 32 * int'(widx[w]) -: 32];
         for (int k = 0; k < 4; k++) begin
            lane_out[w][31 - 8 * k -: 8] = sub_byte(lane_in[w][31 - 8 * k -: 8], 2'(k), type_q);
         end
         data_sub[127 - 32 * int'(widx[w]) -: 32] = lane_out[w];
      end
   end

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      type_d    = type_q;
      data_d    = data_q;
      dout_d    = dout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (sl.sl_in_valid) begin
               data_d  = sl.sl_din;
               type_d  = sl.sl_type;
               state_d = RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            data_d = data_sub;
            if (cnt_q == LAST_STEP) begin
               dout_d  = data_sub;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (sl.sl_out_ready) begin
               state_d = IDLE;
`ifdef ARIA_SL_ZEROIZE_EN
               data_d  = '0;
               type_d  = 1'b0;
               dout_d  = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the data registers are reset too, so an abandoned block never reaches sl_dout.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         type_q  <= 1'b0;
         data_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         data_q  <= data_d;
         dout_q  <= dout_d;
      end
   end

   assign sl.sl_in_ready  = in_ready;
   assign sl.sl_out_valid = out_valid;
   assign sl.sl_busy      = busy;
   assign sl.sl_dout      = dout_q;
endmodule
